// File: rtl/stripe_n_lanes.sv
// Serial-to-parallel lane striper: round-robin passthrough, or aligned groups of
// LANES words with flush for partial groups. One clock, synchronous reset.

module stripe_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             slot_we,
    input  logic             out_we,
    input  logic             take_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] lane_data,
    output logic             lane_valid
);
    logic [WIDTH-1:0] slot_q;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            slot_q     <= '0;
            lane_data  <= '0;
            lane_valid <= 1'b0;
        end else begin
            if (slot_we)
                slot_q <= data_in;
            // The word arriving this cycle bypasses its slot so it lands in the same emission.
            if (out_we)
                lane_data <= take_in ? data_in : slot_q;
            lane_valid <= out_we;
        end
    end
endmodule

module stripe_n_lanes #(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic                   clk_2f,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   valid_in,
    output logic [LANES*WIDTH-1:0] lane_data,
    output logic [LANES-1:0]       lane_valid,
    output logic [15:0]            group_count,
    output logic                   drop
);
    localparam int PW = $clog2(LANES);

    logic                               mode_q;
    logic [PW-1:0]                      ptr;
    logic [LANES-1:0][WIDTH-1:0]        lane_q;
    logic [LANES-1:0]                   hit, in_grp, out_we, slot_we;
    logic [PW:0]                        grp_end;
    logic                               mode_chg, at_last, ptr_nz, emit_al, grp_inc;

    assign mode_chg = mode != mode_q;
    assign at_last  = ptr == PW'(LANES - 1);
    assign ptr_nz   = ptr != '0;
    // Aligned emission: full group on the last word, or a partial group on flush.
    assign emit_al  = mode_q & ((valid_in & (at_last | flush)) | (~valid_in & flush & ptr_nz));
    assign grp_end  = {1'b0, ptr} + {{PW{1'b0}}, valid_in};
    assign grp_inc  = ~mode_chg & (mode_q ? emit_al : (valid_in & at_last));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign hit[k]     = valid_in & (ptr == PW'(k));
        assign in_grp[k]  = (PW+1)'(k) < grp_end;
        assign out_we[k]  = ~mode_chg & (mode_q ? (emit_al & in_grp[k]) : hit[k]);
        assign slot_we[k] = ~mode_chg & mode_q & hit[k];

        stripe_lane #(.WIDTH(WIDTH)) u_lane (
            .clk_2f     (clk_2f),
            .reset      (reset),
            .slot_we    (slot_we[k]),
            .out_we     (out_we[k]),
            .take_in    (hit[k]),
            .data_in    (data_in),
            .lane_data  (lane_q[k]),
            .lane_valid (lane_valid[k])
        );
    end

    assign lane_data = lane_q;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            mode_q      <= 1'b0;
            ptr         <= '0;
            group_count <= '0;
            drop        <= 1'b0;
        end else begin
            drop <= mode_chg & (ptr_nz | valid_in);
            if (grp_inc)
                group_count <= group_count + 16'd1;
            if (mode_chg) begin
                mode_q <= mode;
                ptr    <= '0;
            end else if (mode_q ? emit_al : (valid_in & at_last)) begin
                ptr <= '0;
            end else if (valid_in) begin
                ptr <= ptr + PW'(1);
            end
        end
    end
endmodule
